// File: rtl/vga_pkg.sv
// Shared VGA constants: raster geometry, test-pattern modes and 12-bit {R,G,B} colours.
// Also provides the colour-bar lookup used by the pattern generator.
package vga_pkg;

    localparam logic [9:0]  H_ACTIVE   = 10'd640;
    localparam logic [9:0]  V_ACTIVE   = 10'd480;
    localparam logic [16:0] FB_WIDTH   = 17'd320;
    localparam logic [16:0] FB_HEIGHT  = 17'd240;
    localparam int unsigned GRID_SHIFT = 5;
    localparam logic [9:0]  GRID_MASK  = 10'((1 << GRID_SHIFT) - 1);
    localparam logic [11:0] IDLE_COLOR = 12'h222;

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    localparam logic [11:0] WHITE   = 12'hFFF;
    localparam logic [11:0] YELLOW  = 12'hFF0;
    localparam logic [11:0] CYAN    = 12'h0FF;
    localparam logic [11:0] GREEN   = 12'h0F0;
    localparam logic [11:0] MAGENTA = 12'hF0F;
    localparam logic [11:0] RED     = 12'hF00;
    localparam logic [11:0] BLUE    = 12'h00F;
    localparam logic [11:0] BLACK   = 12'h000;

    // Eight 80-px bars across the 640-px active line.
    function automatic logic [11:0] bar_color(input logic [9:0] x);
        logic [2:0] idx;
        idx = 3'(x / 10'd80);
        case (idx)
            3'd0:    return WHITE;
            3'd1:    return YELLOW;
            3'd2:    return CYAN;
            3'd3:    return GREEN;
            3'd4:    return MAGENTA;
            3'd5:    return RED;
            3'd6:    return BLUE;
            default: return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/fb_scan_reader_if.sv
// Frame-buffer BRAM read port: registered address out, data back one cycle later.
interface fb_scan_reader_if;
    logic [16:0] fb_read_addr;
    logic [11:0] fb_read_data;

    modport master (output fb_read_addr, input  fb_read_data);
    modport slave  (input  fb_read_addr, output fb_read_data);
endinterface

// File: rtl/fb_scan_reader_pattern.sv
// Stage-2 colour source selection: either a generated pattern colour or the BRAM pixel.
module scan_pattern_gen
    import vga_pkg::*;
(
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  mode_e       mode_i,
    input  logic        fb_valid_i,
    output logic [11:0] color_o,
    output logic        use_fb_o
);
    logic grid_line;
    assign grid_line = ((x_i & GRID_MASK) == '0) || ((y_i & GRID_MASK) == '0);

    always_comb begin
        color_o  = BLACK;
        use_fb_o = 1'b0;
        case (mode_i)
            MODE_FB: begin
                use_fb_o = fb_valid_i;
                color_o  = IDLE_COLOR;
            end
            MODE_BARS: color_o = bar_color(x_i);
            MODE_GRID: begin
                if (grid_line) begin
                    color_o = WHITE;
                end else begin
                    use_fb_o = fb_valid_i;
                    color_o  = IDLE_COLOR;
                end
            end
            default: color_o = BLACK;
        endcase
    end
endmodule

// File: rtl/fb_scan_reader.sv
// 2x-upscaling frame-buffer scan-out: address generation, 2-cycle aligned sync/colour
// pipeline and per-frame test-pattern mux.
module fb_scan_reader
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        display_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  mode,
    input  logic        fb_valid,
    fb_scan_reader_if.master fb,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       hs;
        logic       vs;
    } pix_t;

    localparam pix_t PIX_RST = '{x: '0, y: '0, act: 1'b0, hs: 1'b1, vs: 1'b1};

    logic        active_in;
    logic [16:0] addr_d, addr_q;
    pix_t        pix_d;
    pix_t        pipe_q [2];
    mode_e       mode_q;
    logic        fb_valid_q;
    logic [11:0] pat_color, rgb_d, rgb_q;
    logic        use_fb;
    logic        hs_q, vs_q;

    assign active_in = display_on && (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE);
    // Pixel and line doubling: each frame-buffer texel covers a 2x2 block.
    assign addr_d = active_in ? (17'(pixel_y >> 1) * FB_WIDTH + 17'(pixel_x >> 1)) : '0;
    assign pix_d  = '{x: pixel_x, y: pixel_y, act: active_in, hs: hsync_in, vs: vsync_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            pipe_q[0]  <= PIX_RST;
            pipe_q[1]  <= PIX_RST;
            mode_q     <= MODE_FB;
            fb_valid_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            pipe_q[0] <= pix_d;
            pipe_q[1] <= pipe_q[0];
            // Latch only at frame start so a mid-frame change never tears the image.
            if (pixel_x == '0 && pixel_y == '0) begin
                mode_q     <= mode_e'(mode);
                fb_valid_q <= fb_valid;
            end
        end
    end

    scan_pattern_gen u_pattern (
        .x_i        (pipe_q[1].x),
        .y_i        (pipe_q[1].y),
        .mode_i     (mode_q),
        .fb_valid_i (fb_valid_q),
        .color_o    (pat_color),
        .use_fb_o   (use_fb)
    );

    assign rgb_d = !pipe_q[1].act ? BLACK : (use_fb ? fb.fb_read_data : pat_color);

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= pipe_q[1].hs;
            vs_q  <= pipe_q[1].vs;
        end
    end

    assign fb.fb_read_addr = addr_q;
    assign hsync = hs_q;
    assign vsync = vs_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader: vector table for address/latency, hand sequences
// for frame-latched modes, grid/idle, blanking and mid-line reset.
module tb_fb_scan_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        display_on, hsync_in, vsync_in;
    logic [1:0]  mode;
    logic        fb_valid;
    logic        hsync, vsync;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [11:0] rgb;
    logic        force_abc = 1'b0;
    int          checks = 0;
    int          failures = 0;

    fb_scan_reader_if bus ();

    fb_scan_reader dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .display_on (display_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .mode       (mode),
        .fb_valid   (fb_valid),
        .fb         (bus),
        .hsync      (hsync),
        .vsync      (vsync),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b)
    );

    always #20 clk = ~clk;

    // BRAM model: one-cycle read latency, data is the low address bits.
    always_ff @(posedge clk)
        bus.fb_read_data <= force_abc ? 12'hABC : bus.fb_read_addr[11:0];

    assign rgb = {vga_r, vga_g, vga_b};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs);
        pixel_x    = 10'(x);
        pixel_y    = 10'(y);
        display_on = de;
        hsync_in   = hs;
        vsync_in   = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic blank();
        step(700, 700, 1'b0, 1'b1, 1'b1);
    endtask

    // One active pixel followed by two blanks; its colour is out after the second blank.
    task automatic run3(input string name, input int x, input int y, input bit de,
                        input logic [11:0] exp);
        step(x, y, de, 1'b1, 1'b1);
        blank();
        blank();
        chk(name, 32'(rgb), 32'(exp));
    endtask

    typedef struct {
        int          x, y;
        bit          de, hs, vs;
        logic [16:0] addr;
        logic [11:0] rgb;
        bit          ohs, ovs;
    } vec_t;

    vec_t v[14];

    initial begin
        v[0]  = '{0,   0,   1, 1, 1, 17'd0,     12'h000, 1, 1};
        v[1]  = '{1,   0,   1, 1, 1, 17'd0,     12'h000, 1, 1};
        v[2]  = '{2,   0,   1, 1, 1, 17'd1,     12'h001, 1, 1};
        v[3]  = '{3,   0,   1, 1, 1, 17'd1,     12'h001, 1, 1};
        v[4]  = '{0,   1,   1, 1, 1, 17'd0,     12'h000, 1, 1};
        v[5]  = '{1,   1,   1, 1, 1, 17'd0,     12'h000, 1, 1};
        v[6]  = '{2,   1,   1, 1, 1, 17'd1,     12'h001, 1, 1};
        v[7]  = '{3,   1,   1, 0, 1, 17'd1,     12'h001, 0, 1};
        v[8]  = '{639, 479, 1, 1, 1, 17'd76799, 12'hBFF, 1, 1};
        v[9]  = '{4,   2,   0, 1, 1, 17'd0,     12'h000, 1, 1};
        v[10] = '{640, 10,  1, 1, 1, 17'd0,     12'h000, 1, 1};
        v[11] = '{10,  480, 1, 1, 1, 17'd0,     12'h000, 1, 1};
        v[12] = '{100, 3,   1, 1, 0, 17'd370,   12'h172, 1, 0};
        v[13] = '{5,   7,   1, 1, 1, 17'd962,   12'h3C2, 1, 1};

        reset = 1'b1;
        mode = 2'd0;
        fb_valid = 1'b1;
        blank();
        blank();
        chk("reset_addr", 32'(bus.fb_read_addr), 32'd0);
        chk("reset_rgb", 32'(rgb), 32'h000);
        chk("reset_hsync", 32'(hsync), 32'd1);
        chk("reset_vsync", 32'(vsync), 32'd1);
        reset = 1'b0;

        // Table: address checked at its own edge, colour/syncs two edges later.
        for (int i = 0; i < 16; i++) begin
            if (i < 14) step(v[i].x, v[i].y, v[i].de, v[i].hs, v[i].vs);
            else blank();
            if (i < 14) chk($sformatf("addr_v%0d", i), 32'(bus.fb_read_addr), 32'(v[i].addr));
            if (i >= 2) begin
                chk($sformatf("rgb_v%0d", i-2), 32'(rgb), 32'(v[i-2].rgb));
                chk($sformatf("hsync_v%0d", i-2), 32'(hsync), 32'(v[i-2].ohs));
                chk($sformatf("vsync_v%0d", i-2), 32'(vsync), 32'(v[i-2].ovs));
            end
        end

        // Latency/alignment of an hsync pulse with its colour.
        step(7, 9, 1'b1, 1'b0, 1'b1);
        chk("lat_addr", 32'(bus.fb_read_addr), 32'd1283);
        chk("lat_hs_t0", 32'(hsync), 32'd1);
        blank();
        chk("lat_hs_t1", 32'(hsync), 32'd1);
        chk("lat_rgb_t1", 32'(rgb), 32'h000);
        blank();
        chk("lat_hs_t2", 32'(hsync), 32'd0);
        chk("lat_rgb_t2", 32'(rgb), 32'h503);
        blank();
        chk("lat_hs_t3", 32'(hsync), 32'd1);

        // Grid with idle frame buffer.
        mode = 2'd2;
        fb_valid = 1'b0;
        run3("grid_origin", 0, 0, 1'b1, 12'hFFF);
        run3("grid_x32", 32, 5, 1'b1, 12'hFFF);
        run3("grid_x33_idle", 33, 5, 1'b1, 12'h222);
        run3("grid_y32", 33, 32, 1'b1, 12'hFFF);

        // Frame-synchronous mode switch.
        mode = 2'd0;
        fb_valid = 1'b1;
        run3("fs_frame_start", 0, 0, 1'b1, 12'h000);
        run3("fs_fb_before", 80, 100, 1'b1, 12'hEA8);
        mode = 2'd1;
        run3("fs_fb_midframe", 81, 100, 1'b1, 12'hEA8);
        run3("fs_bar0_x0", 0, 0, 1'b1, 12'hFFF);
        run3("fs_bar0_x79", 79, 0, 1'b1, 12'hFFF);
        run3("fs_bar1_x80", 80, 0, 1'b1, 12'hFF0);
        run3("fs_bar5_x479", 479, 0, 1'b1, 12'hF00);
        run3("fs_bar6_x559", 559, 0, 1'b1, 12'h00F);
        run3("fs_bar7_x560", 560, 0, 1'b1, 12'h000);

        // Blanking forces black even with data present.
        mode = 2'd0;
        run3("blank_frame_start", 0, 0, 1'b1, 12'h000);
        force_abc = 1'b1;
        run3("blank_de0", 10, 10, 1'b0, 12'h000);
        run3("blank_de1", 10, 10, 1'b1, 12'hABC);
        force_abc = 1'b0;

        // Mid-line reset with bars latched and active pixels in flight.
        mode = 2'd1;
        run3("rst_bars_latch", 0, 0, 1'b1, 12'hFFF);
        step(299, 50, 1'b1, 1'b0, 1'b0);
        step(300, 50, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step(301, 50, 1'b1, 1'b0, 1'b0);
        chk("rst_addr", 32'(bus.fb_read_addr), 32'd0);
        chk("rst_rgb", 32'(rgb), 32'h000);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        step(302, 50, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        step(301, 50, 1'b1, 1'b1, 1'b1);
        chk("rst_rel_rgb_t0", 32'(rgb), 32'h000);
        chk("rst_rel_hs_t0", 32'(hsync), 32'd1);
        blank();
        chk("rst_rel_rgb_t1", 32'(rgb), 32'h000);
        chk("rst_rel_vs_t1", 32'(vsync), 32'd1);
        blank();
        chk("rst_mode_cleared", 32'(rgb), 32'h222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
